intr_controller: RTL and testbench
==================================

# intr_controller

Parametrised vectored interrupt controller with nesting; successor to the 8-bit two-register manager in the CPU. Latches N request lines (per-channel edge or level mode) and applies an enable mask and fixed priority (lowest index = highest). Raises a single `irq` with a frozen vector to the CPU via a request/acknowledge handshake, and tracks nested in-service levels until end-of-interrupt. Sits between peripheral interrupt sources and the CPU control unit.

## Interface
- `N_INTR`, 8: number of interrupt channels, 2..32.
- `EDGE_MASK`, {N_INTR{1'b1}}: per-channel mode; 1 = rising-edge, 0 = level-high.
- `VEC_W`, derived localparam $clog2(N_INTR): vector width; not overridable.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous reset, active-low; state cleared on a `clk` edge while `reset`=0.
- `intr_in`  in  N_INTR  raw interrupt requests, already synchronous to `clk`.
- `intr_en`  in  N_INTR  enable mask; 0 blocks a channel from being presented, but does not block latching into pending.
- `cpu_ack`  in  1  CPU accepts the presented interrupt (jump to handler).
- `eoi`  in  1  end of interrupt (return from handler), one-cycle pulse.
- `irq`  out  1  interrupt request to CPU.
- `vec`  out  VEC_W  channel index of the presented interrupt; valid while `irq`=1.
- `pending`  out  N_INTR  latched, not-yet-accepted requests.
- `in_service`  out  N_INTR  accepted, not-yet-ended interrupts.

## Operation
- Reset: `pending`, `in_service`, `vec`, previous-input register = 0; `irq`=0; FSM = IDLE.
- Latching, edge channel: `pending[i]` is set when `intr_in[i]`=1 and the registered previous value was 0.
- Latching, level channel: `pending[i]` is set on every cycle `intr_in[i]`=1.
- Set has priority over the acceptance clear in the same cycle.
- Candidate: lowest-index bit of `pending & intr_en` whose index is strictly below the lowest set bit of `in_service`. With `in_service`=0, any index qualifies. Equal or lower priority never preempts.
- FSM, IDLE: `irq`=0. If a candidate exists → PRESENT, latch `vec` = candidate index.
- FSM, PRESENT: `irq`=1 and `vec` is frozen. Changes to mask or pending do not withdraw or alter the request.
- FSM, PRESENT on `cpu_ack`=1: set `in_service[vec]`, clear `pending[vec]`, go to IDLE.
- `cpu_ack` in IDLE is ignored.
- `eoi`: clears the lowest set bit of `in_service` (the innermost handler). With `in_service`=0 it is ignored.
- `eoi` and acceptance in the same cycle: `eoi` clears based on the pre-update `in_service`, then the accepted bit is set.
- Nesting depth is bounded only by N_INTR.
- Reset mid-handshake: `irq` drops on the next edge; the CPU must also be reset.

## Timing
- Edge sampled at clock edge k → `pending` set after k → `irq`=1 and `vec` valid after edge k+1. Latency is 2 cycles.
- `cpu_ack` at edge k → after k: `irq`=0, `in_service` updated.
- Earliest next `irq` is after edge k+1.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package/header `intr_defs`: FSM state encodings (IDLE=1'b0, PRESENT=1'b1) and the N_INTR range limits.
- Sub-module `intr_prio_enc` #(W): lowest-set-bit one-hot (-x & x) plus binary index and a valid flag.
- Instantiate `intr_prio_enc` twice: once for candidate selection, once for the in-service level.
- Registers use the existing `registro` style, adapted to active-low synchronous reset.

## Test plan
(All cases N_INTR=8, EDGE_MASK=8'hFF.)
- Reset: hold `reset`=0 with `intr_in`=8'hFF → `irq`=0, `vec`=0, `pending`=0, `in_service`=0.
- Single edge on ch5, `intr_en`=8'hFF → `irq`=1 with `vec`=5 two cycles later. Then `cpu_ack` → `in_service`=8'h20, `pending`=0. Then `eoi` → `in_service`=0.
- Nesting: ch5 in service, edge on ch2 → `vec`=2, ack → `in_service`=8'h24. Then edge on ch6 → no `irq`. Then `eoi` → 8'h20, `eoi` → 0, after which ch6 is presented.
- Masking: edge on ch3 with `intr_en`=8'hF7 → `pending`=8'h08, `irq`=0. Set `intr_en`=8'hFF → `irq`, `vec`=3 after 1 cycle.
- Frozen vector: ch4 presented, then edge on ch1 before ack → `vec` stays 4. After ack, ch1 is presented (preempts 4).
- Simultaneous events: level mode ch0 (EDGE_MASK=8'hFE) held high → re-pends after ack, but no `irq` while ch0 is in service. Also check `eoi`+`cpu_ack` in the same cycle → old bit cleared and new bit set.

Source files
------------

// File: rtl/intr_defs.sv
// Shared definitions for the vectored interrupt controller:
// FSM state encoding and supported channel-count range.
package intr_defs;

  localparam int N_INTR_MIN = 2;
  localparam int N_INTR_MAX = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot (-x & x), index, valid.
// Ports: x in W; onehot out W; idx out IW; valid out 1.
module intr_prio_enc #(
  parameter  int W  = 8,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  x,
  output logic [W-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  assign onehot = x & (~x + W'(1));
  assign valid  = |x;

  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (onehot[i]) idx = idx | IW'(i);
    end
  end

endmodule

// File: rtl/intr_controller.sv
// Vectored, nesting interrupt controller with req/ack handshake.
// Ports: clk, reset(n); intr_in/intr_en/cpu_ack/eoi in; irq/vec/pending/in_service out.
module intr_controller
  import intr_defs::*;
#(
  parameter  int                N_INTR    = 8,
  parameter  logic [N_INTR-1:0] EDGE_MASK = {N_INTR{1'b1}},
  localparam int                VEC_W     = $clog2(N_INTR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_INTR-1:0] intr_in,
  input  logic [N_INTR-1:0] intr_en,
  input  logic              cpu_ack,
  input  logic              eoi,
  output logic              irq,
  output logic [VEC_W-1:0]  vec,
  output logic [N_INTR-1:0] pending,
  output logic [N_INTR-1:0] in_service
);

  if (N_INTR < N_INTR_MIN || N_INTR > N_INTR_MAX) begin : g_bad_n
    $error("intr_controller: N_INTR out of range");
  end

  state_t            state;
  logic [N_INTR-1:0] prev;
  logic [N_INTR-1:0] vec_oh;

  logic [N_INTR-1:0] set_v;
  logic [N_INTR-1:0] pend_nxt;
  logic [N_INTR-1:0] isr_nxt;
  logic              accept;

  logic [N_INTR-1:0] cand_oh;
  logic [VEC_W-1:0]  cand_idx;
  logic              cand_valid;
  logic              cand_ok;

  logic [N_INTR-1:0] isr_oh;
  logic [VEC_W-1:0]  isr_idx;
  logic              isr_valid;

  assign set_v = (EDGE_MASK & intr_in & ~prev)
               | (~EDGE_MASK & intr_in);

  assign accept = (state == PRESENT) && cpu_ack;

  // Set wins over the acceptance clear.
  assign pend_nxt = (pending & ~(accept ? vec_oh : '0))
                  | set_v;

  // EOI acts on the pre-update innermost level.
  assign isr_nxt = (in_service & ~(eoi ? isr_oh : '0))
                 | (accept ? vec_oh : '0);

  intr_prio_enc #(.W(N_INTR)) u_cand (
    .x      (pending & intr_en),
    .onehot (cand_oh),
    .idx    (cand_idx),
    .valid  (cand_valid)
  );

  intr_prio_enc #(.W(N_INTR)) u_level (
    .x      (in_service),
    .onehot (isr_oh),
    .idx    (isr_idx),
    .valid  (isr_valid)
  );

  // Lowest enabled pending bit is the only one that can
  // beat the current level; if it can't, nothing can.
  assign cand_ok = cand_valid
                && (!isr_valid || cand_idx < isr_idx);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      prev       <= '0;
      pending    <= '0;
      in_service <= '0;
      irq        <= 1'b0;
      vec        <= '0;
      vec_oh     <= '0;
    end else begin
      prev       <= intr_in;
      pending    <= pend_nxt;
      in_service <= isr_nxt;
      unique case (state)
        IDLE: begin
          if (cand_ok) begin
            state  <= PRESENT;
            irq    <= 1'b1;
            vec    <= cand_idx;
            vec_oh <= cand_oh;
          end
        end
        PRESENT: begin
          if (cpu_ack) begin
            state <= IDLE;
            irq   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_controller.sv
// Self-checking bench for intr_controller (edge and level instances).
// Presented vectors are scoreboarded; state checked directly.
module tb_intr_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] intr_in, intr_en;
  logic       cpu_ack, eoi;
  logic       irq;
  logic [2:0] vec;
  logic [7:0] pending, in_service;

  logic [7:0] intr_in2, intr_en2;
  logic       cpu_ack2, eoi2;
  logic       irq2;
  logic [2:0] vec2;
  logic [7:0] pending2, in_service2;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  logic irq_q = 1'b0;

  always #5 clk = ~clk;

  intr_controller #(.N_INTR(8), .EDGE_MASK(8'hFF)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .intr_in    (intr_in),
    .intr_en    (intr_en),
    .cpu_ack    (cpu_ack),
    .eoi        (eoi),
    .irq        (irq),
    .vec        (vec),
    .pending    (pending),
    .in_service (in_service)
  );

  intr_controller #(.N_INTR(8), .EDGE_MASK(8'hFE)) u_lvl (
    .clk        (clk),
    .reset      (reset),
    .intr_in    (intr_in2),
    .intr_en    (intr_en2),
    .cpu_ack    (cpu_ack2),
    .eoi        (eoi2),
    .irq        (irq2),
    .vec        (vec2),
    .pending    (pending2),
    .in_service (in_service2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic edge_in(input logic [7:0] m);
    intr_in = m;
    cyc(1);
    intr_in = '0;
  endtask

  task automatic ack_pulse;
    cpu_ack = 1'b1;
    cyc(1);
    cpu_ack = 1'b0;
  endtask

  task automatic eoi_pulse;
    eoi = 1'b1;
    cyc(1);
    eoi = 1'b0;
  endtask

  // Scoreboard: each new presentation pops one expected vector.
  always @(negedge clk) begin
    if (reset && irq && !irq_q) begin
      if (exp_q.size() == 0) chk("vec_unexp", {31'b0, irq}, 0);
      else chk("vec", {29'b0, vec}, exp_q.pop_front());
    end
    irq_q <= irq;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    intr_in = 8'hFF; intr_en = 8'hFF;
    cpu_ack = 1'b0; eoi = 1'b0;
    intr_in2 = 8'hFF; intr_en2 = 8'hFF;
    cpu_ack2 = 1'b0; eoi2 = 1'b0;
    cyc(3);
    chk("rst_irq", {31'b0, irq}, 0);
    chk("rst_vec", {29'b0, vec}, 0);
    chk("rst_pend", {24'b0, pending}, 0);
    chk("rst_isr", {24'b0, in_service}, 0);
    chk("rst_pend2", {24'b0, pending2}, 0);
    intr_in = '0; intr_in2 = '0;
    cyc(1);
    reset = 1'b1;
    cyc(1);

    // single edge on ch5
    exp_q.push_back(5);
    intr_in = 8'h20;
    cyc(1);
    intr_in = '0;
    chk("s_pend", {24'b0, pending}, 32'h20);
    chk("s_irq0", {31'b0, irq}, 0);
    cyc(1);
    chk("s_irq1", {31'b0, irq}, 1);
    ack_pulse();
    chk("s_ackirq", {31'b0, irq}, 0);
    chk("s_isr", {24'b0, in_service}, 32'h20);
    chk("s_pend0", {24'b0, pending}, 0);
    eoi_pulse();
    chk("s_eoi", {24'b0, in_service}, 0);

    // nesting
    exp_q.push_back(5);
    edge_in(8'h20);
    cyc(1);
    ack_pulse();
    exp_q.push_back(2);
    edge_in(8'h04);
    cyc(1);
    chk("n_irq", {31'b0, irq}, 1);
    ack_pulse();
    chk("n_isr24", {24'b0, in_service}, 32'h24);
    edge_in(8'h40);
    cyc(3);
    chk("n_blk", {31'b0, irq}, 0);
    chk("n_pend", {24'b0, pending}, 32'h40);
    eoi_pulse();
    chk("n_isr20", {24'b0, in_service}, 32'h20);
    chk("n_blk2", {31'b0, irq}, 0);
    exp_q.push_back(6);
    eoi_pulse();
    chk("n_isr0", {24'b0, in_service}, 0);
    cyc(1);
    chk("n_ch6", {31'b0, irq}, 1);
    ack_pulse();
    eoi_pulse();

    // masking
    intr_en = 8'hF7;
    edge_in(8'h08);
    cyc(2);
    chk("m_pend", {24'b0, pending}, 32'h08);
    chk("m_irq0", {31'b0, irq}, 0);
    exp_q.push_back(3);
    intr_en = 8'hFF;
    cyc(1);
    chk("m_irq1", {31'b0, irq}, 1);
    ack_pulse();
    eoi_pulse();
    chk("m_isr", {24'b0, in_service}, 0);

    // frozen vector, then preemption by ch1
    exp_q.push_back(4);
    edge_in(8'h10);
    cyc(1);
    edge_in(8'h02);
    chk("f_vec", {29'b0, vec}, 4);
    chk("f_pend", {24'b0, pending}, 32'h12);
    chk("f_irq", {31'b0, irq}, 1);
    exp_q.push_back(1);
    ack_pulse();
    chk("f_isr10", {24'b0, in_service}, 32'h10);
    cyc(1);
    chk("f_pre", {31'b0, irq}, 1);
    ack_pulse();
    chk("f_isr12", {24'b0, in_service}, 32'h12);
    eoi_pulse();
    chk("f_eoi1", {24'b0, in_service}, 32'h10);
    eoi_pulse();
    chk("f_eoi2", {24'b0, in_service}, 0);

    // eoi and ack in the same cycle
    exp_q.push_back(5);
    edge_in(8'h20);
    cyc(1);
    ack_pulse();
    exp_q.push_back(2);
    edge_in(8'h04);
    cyc(1);
    cpu_ack = 1'b1; eoi = 1'b1;
    cyc(1);
    cpu_ack = 1'b0; eoi = 1'b0;
    chk("x_isr", {24'b0, in_service}, 32'h04);
    eoi_pulse();
    chk("x_isr0", {24'b0, in_service}, 0);

    // level channel 0 on the second instance
    intr_in2 = 8'h01;
    cyc(1);
    chk("l_pend", {24'b0, pending2}, 32'h01);
    cyc(1);
    chk("l_irq", {31'b0, irq2}, 1);
    chk("l_vec", {29'b0, vec2}, 0);
    cpu_ack2 = 1'b1;
    cyc(1);
    cpu_ack2 = 1'b0;
    chk("l_isr", {24'b0, in_service2}, 32'h01);
    chk("l_repend", {24'b0, pending2}, 32'h01);
    cyc(3);
    chk("l_blk", {31'b0, irq2}, 0);
    intr_in2 = '0;
    eoi2 = 1'b1;
    cyc(1);
    eoi2 = 1'b0;
    chk("l_eoi", {24'b0, in_service2}, 0);
    cyc(1);
    chk("l_again", {31'b0, irq2}, 1);
    cpu_ack2 = 1'b1;
    cyc(1);
    cpu_ack2 = 1'b0;
    chk("l_pend0", {24'b0, pending2}, 0);

    cyc(2);
    chk("q_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
